// File: rtl/value_search.sv
// value_search: sequential equality search engine.
// A candidate counter sweeps upward from 0 to a captured limit. Each cycle the
// candidate is compared against a captured target. The block reports the first
// match, or reports that no value in range matches.
// Optional feature macro: VALUE_SEARCH_ABORT_EN adds an 'abort' input that ends
// a running search early with found=0.
module value_search #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
`ifdef VALUE_SEARCH_ABORT_EN
    input  logic         abort,
`endif
    input  logic [W-1:0] target,
    input  logic [W-1:0] limit,
    output logic         busy,
    output logic         done,
    output logic         found,
    output logic [W-1:0] result
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_SEARCH = 1'b1
    } state_t;

    state_t         r_state;
    logic [W-1:0]   r_cand;
    logic [W-1:0]   r_target;
    logic [W-1:0]   r_limit;
    logic           r_busy;
    logic           r_done;
    logic           r_found;
    logic [W-1:0]   r_result;

    logic           w_hit;
    logic           w_at_limit;
    logic           w_abort;

    // Bitwise equality: every bit pair must agree (XNOR, then AND-reduce).
    function automatic logic eq_w(input logic [W-1:0] a, input logic [W-1:0] b);
        return &(a ~^ b);
    endfunction

    assign w_hit      = eq_w(r_cand, r_target);
    assign w_at_limit = eq_w(r_cand, r_limit);
`ifdef VALUE_SEARCH_ABORT_EN
    assign w_abort    = abort;
`else
    assign w_abort    = 1'b0;
`endif

    // Search controller: captures the request, steps the candidate, and
    // registers the completion outputs. The candidate stops at the limit, so
    // it never wraps even when the limit is the all-ones value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cand   <= '0;
            r_target <= '0;
            r_limit  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_found  <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_target <= target;
                        r_limit  <= limit;
                        r_cand   <= '0;
                        r_found  <= 1'b0;
                        r_result <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_SEARCH;
                    end
                end
                S_SEARCH: begin
                    if (w_abort) begin
                        r_found  <= 1'b0;
                        r_result <= '0;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end else if (w_hit) begin
                        r_found  <= 1'b1;
                        r_result <= r_cand;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end else if (w_at_limit) begin
                        r_found  <= 1'b0;
                        r_result <= '0;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end else begin
                        r_cand <= r_cand + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign found  = r_found;
    assign result = r_result;

endmodule

// File: tb/tb_value_search.sv
// tb_value_search: scoreboard bench for value_search.
// Expected completions are pushed when a search is launched and popped when
// the DUT raises done. Define VALUE_SEARCH_ABORT_EN to cover the abort input.
module tb_value_search;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b1;
    logic [W-1:0] target = '0;
    logic [W-1:0] limit = '0;
`ifdef VALUE_SEARCH_ABORT_EN
    logic         abort = 1'b0;
`endif
    logic         busy;
    logic         done;
    logic         found;
    logic [W-1:0] result;

    typedef struct {
        logic         f;
        logic [W-1:0] r;
        int           lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Observations from the most recent wait_done call.
    int           o_lat;
    int           o_busy;
    logic         o_f;
    logic [W-1:0] o_r;
    bit           o_to;
    logic         o_d0;
    logic         o_f0;
    logic [W-1:0] o_r0;

    value_search #(.W(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
`ifdef VALUE_SEARCH_ABORT_EN
        .abort  (abort),
`endif
        .target (target),
        .limit  (limit),
        .busy   (busy),
        .done   (done),
        .found  (found),
        .result (result)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] t, input logic [W-1:0] l);
        exp_t e;
        if (t <= l) begin
            e.f = 1'b1; e.r = t; e.lat = int'(t) + 1;
        end else begin
            e.f = 1'b0; e.r = '0; e.lat = int'(l) + 1;
        end
        return e;
    endfunction

    // Present a request at a falling edge; it is accepted at the next rising edge.
    task automatic launch(input logic [W-1:0] t, input logic [W-1:0] l);
        @(negedge clk);
        start = 1'b1; target = t; limit = l;
        sb_q.push_back(model(t, l));
    endtask

    // Sample k is taken at the falling edge after acceptance edge N + k.
    task automatic wait_done(input int poke_k, input logic [W-1:0] poke_t, input int abort_k);
        o_to = 1'b1; o_busy = 0; o_lat = -1; o_f = 1'bx; o_r = 'x;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            start = (k == poke_k);
            if (k == poke_k) target = poke_t;
`ifdef VALUE_SEARCH_ABORT_EN
            abort = (k == abort_k);
`endif
            if (k == 0) begin o_d0 = done; o_f0 = found; o_r0 = result; end
            if (busy === 1'b1) o_busy++;
            if (done === 1'b1) begin
                o_lat = k; o_f = found; o_r = result; o_to = 1'b0;
                break;
            end
        end
        start = 1'b0;
`ifdef VALUE_SEARCH_ABORT_EN
        abort = 1'b0;
`endif
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++; if (busy !== 1'b0)  begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
            n_cmp++; if (done !== 1'b0)  begin n_err++; $display("FAIL rst_done got %b want 0", done); end
            n_cmp++; if (found !== 1'b0) begin n_err++; $display("FAIL rst_found got %b want 0", found); end
            n_cmp++; if (result !== '0)  begin n_err++; $display("FAIL rst_result got %0d want 0", result); end
        end
        rst = 1'b0; start = 1'b0;
    endtask

    task automatic test_search(input string nm, input logic [W-1:0] t, input logic [W-1:0] l);
        exp_t e;
        launch(t, l);
        wait_done(-1, '0, -1);
        e = sb_q.pop_front();
        n_cmp++; if (o_to)             begin n_err++; $display("FAIL %s_timeout no done within bound", nm); end
        n_cmp++; if (o_f !== e.f)      begin n_err++; $display("FAIL %s_found got %b want %b", nm, o_f, e.f); end
        n_cmp++; if (o_r !== e.r)      begin n_err++; $display("FAIL %s_result got %0d want %0d", nm, o_r, e.r); end
        n_cmp++; if (o_lat != e.lat)   begin n_err++; $display("FAIL %s_latency got %0d want %0d", nm, o_lat, e.lat); end
        n_cmp++; if (o_busy != e.lat)  begin n_err++; $display("FAIL %s_busy_cycles got %0d want %0d", nm, o_busy, e.lat); end
        // Outputs are held and done drops after one cycle.
        @(negedge clk);
        n_cmp++; if (done !== 1'b0)    begin n_err++; $display("FAIL %s_done_pulse got %b want 0", nm, done); end
        n_cmp++; if (busy !== 1'b0)    begin n_err++; $display("FAIL %s_idle_busy got %b want 0", nm, busy); end
        n_cmp++; if (found !== e.f)    begin n_err++; $display("FAIL %s_found_hold got %b want %b", nm, found, e.f); end
        n_cmp++; if (result !== e.r)   begin n_err++; $display("FAIL %s_result_hold got %0d want %0d", nm, result, e.r); end
    endtask

    task automatic test_match();
        test_search("match", 4'd9, 4'd15);
    endtask

    task automatic test_not_found();
        test_search("notfound", 4'd12, 4'd5);
        test_search("lim0", 4'd5, 4'd0);
    endtask

    task automatic test_corners();
        test_search("zero", 4'd0, 4'd0);
        test_search("max", 4'd15, 4'd15);
        test_search("eq", 4'd7, 4'd7);
    endtask

    task automatic test_ignore();
        exp_t e;
        launch(4'd9, 4'd15);
        wait_done(3, 4'd2, -1);
        e = sb_q.pop_front();
        n_cmp++; if (o_to)            begin n_err++; $display("FAIL ign_timeout no done within bound"); end
        n_cmp++; if (o_f !== e.f)     begin n_err++; $display("FAIL ign_found got %b want %b", o_f, e.f); end
        n_cmp++; if (o_r !== e.r)     begin n_err++; $display("FAIL ign_result got %0d want %0d", o_r, e.r); end
        n_cmp++; if (o_lat != e.lat)  begin n_err++; $display("FAIL ign_latency got %0d want %0d", o_lat, e.lat); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0)   begin n_err++; $display("FAIL ign_no_restart busy got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        launch(4'd3, 4'd15);
        wait_done(-1, '0, -1);
        e = sb_q.pop_front();
        n_cmp++; if (o_f !== e.f || o_r !== e.r) begin n_err++; $display("FAIL b2b_first got %b/%0d want %b/%0d", o_f, o_r, e.f, e.r); end
        // Still in the done cycle: request the next search now.
        start = 1'b1; target = 4'd6; limit = 4'd15;
        sb_q.push_back(model(4'd6, 4'd15));
        wait_done(-1, '0, -1);
        e = sb_q.pop_front();
        n_cmp++; if (o_d0 !== 1'b0)   begin n_err++; $display("FAIL b2b_done_clear got %b want 0", o_d0); end
        n_cmp++; if (o_f0 !== 1'b0)   begin n_err++; $display("FAIL b2b_found_clear got %b want 0", o_f0); end
        n_cmp++; if (o_r0 !== '0)     begin n_err++; $display("FAIL b2b_result_clear got %0d want 0", o_r0); end
        n_cmp++; if (o_to)            begin n_err++; $display("FAIL b2b_timeout no done within bound"); end
        n_cmp++; if (o_f !== e.f)     begin n_err++; $display("FAIL b2b_found got %b want %b", o_f, e.f); end
        n_cmp++; if (o_r !== e.r)     begin n_err++; $display("FAIL b2b_result got %0d want %0d", o_r, e.r); end
        n_cmp++; if (o_lat != e.lat)  begin n_err++; $display("FAIL b2b_latency got %0d want %0d", o_lat, e.lat); end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        launch(4'd9, 4'd15);
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        e = sb_q.pop_front();  // aborted by reset; never completes
        n_cmp++; if (busy !== 1'b0)   begin n_err++; $display("FAIL rmid_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0)   begin n_err++; $display("FAIL rmid_done got %b want 0", done); end
        n_cmp++; if (found !== 1'b0)  begin n_err++; $display("FAIL rmid_found got %b want 0", found); end
        n_cmp++; if (result !== '0)   begin n_err++; $display("FAIL rmid_result got %0d want 0", result); end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rmid_late_done got %b want 0 at %0d", done, i); end
        end
    endtask

`ifdef VALUE_SEARCH_ABORT_EN
    task automatic test_abort();
        exp_t e;
        launch(4'd3, 4'd15);
        void'(sb_q.pop_back());
        e.f = 1'b0; e.r = '0; e.lat = 4;
        sb_q.push_back(e);
        wait_done(-1, '0, 3);
        e = sb_q.pop_front();
        n_cmp++; if (o_to)            begin n_err++; $display("FAIL abort_timeout no done within bound"); end
        n_cmp++; if (o_f !== e.f)     begin n_err++; $display("FAIL abort_found got %b want %b", o_f, e.f); end
        n_cmp++; if (o_r !== e.r)     begin n_err++; $display("FAIL abort_result got %0d want %0d", o_r, e.r); end
        n_cmp++; if (o_lat != e.lat)  begin n_err++; $display("FAIL abort_latency got %0d want %0d", o_lat, e.lat); end
    endtask
`endif

    initial begin
        test_reset();
        test_match();
        test_not_found();
        test_corners();
        test_ignore();
        test_back_to_back();
        test_reset_mid();
`ifdef VALUE_SEARCH_ABORT_EN
        test_abort();
`endif
        n_cmp++; if (sb_q.size() != 0) begin n_err++; $display("FAIL sb_leftover got %0d want 0", sb_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
